// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-lane synchronizer, debounce filter and press/release/long event generator
// Optional long-hold detection is enabled by defining LONG_PRESS_EN.
module button_debounce #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int LONG_CYCLES     = 12_000_000
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] button_i,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o,
  output logic [NUM_BUTTONS-1:0] long_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  // Raw pad levels are active-low; the synchronizer idles at 1 (released).
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];
  // pressed_q is the inverted accepted (stable) level, so stable = ~pressed_q.
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;

  // Two-flop synchronizer per lane
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  // Consecutive-sample filter: any sample matching the stable level restarts the count
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sync2_q[i] == ~pressed_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]     = '0;
        pressed_d[i] = ~sync2_q[i];
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Filter state and registered event outputs
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HoldSat  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HoldFire = HW'(LONG_CYCLES - 1);

  logic [HW-1:0]          hold_q [NUM_BUTTONS];
  logic [HW-1:0]          hold_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] long_q, long_d;

  // Hold counter saturates past the fire point so long_o pulses once per press
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!pressed_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HoldSat) begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
      long_d[i] = (hold_q[i] == HoldFire);
    end
  end

  // Hold counters and long-press pulse register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  // Feature disabled: the constant-false term keeps LONG_CYCLES referenced.
  assign long_o = {NUM_BUTTONS{LONG_CYCLES < 0}};
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized and directed self-checking bench for button_debounce
module tb_button_debounce;

  localparam int N = 3;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] button_i = '1;
  logic [N-1:0] pressed_o, press_o, release_o, long_o;

  button_debounce #(
    .NUM_BUTTONS(N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .button_i(button_i),
    .pressed_o(pressed_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic release_now = 1'b0;

  // Reference model: raw level seen at each of the recent edges (index 0 = newest).
  logic [N-1:0] hist [0:D+1];
  logic [N-1:0] mstable;
  int           press_edge [N];
  int           rel_edge [N];
  logic [N-1:0] exp_press, exp_rel, exp_long;

  // Observed DUT activity
  int npress [N];
  int nrel [N];
  int nlong [N];
  int last_press_cyc [N];
  int last_rel_cyc [N];
  int last_long_cyc [N];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) hist[k] = '1;
    mstable   = '1;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    for (int l = 0; l < N; l++) begin
      press_edge[l] = -1000;
      rel_edge[l]   = -1000;
    end
  endtask

  // A lane accepts a new level when the synchronized samples of the last D edges
  // (raw levels from 2..D+1 edges ago) all differ from its accepted level.
  task automatic model_edge();
    bit acc;
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = button_i;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    for (int l = 0; l < N; l++) begin
`ifdef LONG_PRESS_EN
      exp_long[l] = (cyc == press_edge[l] + L) &&
                    (rel_edge[l] < press_edge[l] || rel_edge[l] >= cyc - 1);
`endif
      acc = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (hist[k][l] == mstable[l]) acc = 1'b0;
      if (acc) begin
        mstable[l] = ~mstable[l];
        if (mstable[l] == 1'b0) begin
          exp_press[l]  = 1'b1;
          press_edge[l] = cyc;
        end else begin
          exp_rel[l]  = 1'b1;
          rel_edge[l] = cyc;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] b);
    @(negedge clk);
    button_i = b;
    if (release_now) begin
      rst_ni      = 1'b1;
      release_now = 1'b0;
    end
    @(posedge clk);
    cyc++;
    if (!rst_ni) model_reset();
    else model_edge();
    #1;
    chk("pressed", pressed_o, ~mstable);
    chk("press", press_o, exp_press);
    chk("release", release_o, exp_rel);
    chk("long", long_o, exp_long);
    for (int l = 0; l < N; l++) begin
      if (press_o[l])   begin npress[l]++; last_press_cyc[l] = cyc; end
      if (release_o[l]) begin nrel[l]++;   last_rel_cyc[l]   = cyc; end
      if (long_o[l])    begin nlong[l]++;  last_long_cyc[l]  = cyc; end
    end
  endtask

  task automatic steps(input logic [N-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Assert reset between edges and check outputs clear without waiting for a clock.
  task automatic async_reset(input logic [N-1:0] b, input int hold);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_pressed", pressed_o, '0);
    chk("async_rst_press", press_o, '0);
    chk("async_rst_long", long_o, '0);
    model_reset();
    steps(b, hold);
    release_now = 1'b1;
  endtask

  initial begin
    int t, nb;
    logic [N-1:0] rb;
    int len;
    model_reset();
    for (int l = 0; l < N; l++) begin
      npress[l] = 0; nrel[l] = 0; nlong[l] = 0;
      last_press_cyc[l] = -1; last_rel_cyc[l] = -1; last_long_cyc[l] = -1;
    end

    // Reset, then idle released
    steps(3'b111, 3);
    release_now = 1'b1;
    steps(3'b111, 50);
    chk_int("idle_no_press", npress[0] + npress[1] + npress[2], 0);

    // Clean press and release on lane 0
    t = cyc;
    steps(3'b110, 10);
    chk_int("press0_latency", last_press_cyc[0], t + 6);
    chk("press0_level", pressed_o, 3'b001);
    t = cyc;
    steps(3'b111, 10);
    chk_int("release0_latency", last_rel_cyc[0], t + 6);

    // Bouncing lane 1 yields a single press timed from the final low level
    nb = npress[1];
    step(3'b101); step(3'b111); step(3'b101); step(3'b111);
    t = cyc;
    steps(3'b101, 10);
    chk_int("bounce1_count", npress[1] - nb, 1);
    chk_int("bounce1_latency", last_press_cyc[1], t + 6);
    steps(3'b111, 10);

    // Short low pulse on lane 2 is rejected
    nb = npress[2];
    steps(3'b011, 3);
    steps(3'b111, 10);
    chk_int("glitch2_no_press", npress[2] - nb, 0);

    // All lanes together, then reset while held and re-debounce
    t = cyc;
    steps(3'b000, 8);
    chk_int("all_press_l0", last_press_cyc[0], t + 6);
    chk_int("all_press_l2", last_press_cyc[2], t + 6);
    async_reset(3'b000, 3);
    t = cyc;
    steps(3'b000, 8);
    chk_int("rst_repress_l0", last_press_cyc[0], t + 6);
    chk_int("rst_repress_l1", last_press_cyc[1], t + 6);
    chk_int("rst_repress_l2", last_press_cyc[2], t + 6);
    steps(3'b111, 10);

    // Long hold on lane 0, then a hold too short for long_o
    nb = nlong[0];
    steps(3'b110, 40);
`ifdef LONG_PRESS_EN
    chk_int("long_once", nlong[0] - nb, 1);
    chk_int("long_latency", last_long_cyc[0], last_press_cyc[0] + L);
`else
    chk_int("long_disabled", nlong[0] - nb, 0);
`endif
    steps(3'b111, 10);
    nb = nlong[0];
    steps(3'b110, 15);
    steps(3'b111, 10);
    chk_int("long_short_hold", nlong[0] - nb, 0);

    // Randomized bursts with occasional asynchronous resets
    for (int s = 0; s < 150; s++) begin
      rb  = N'($urandom);
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 29) == 0) async_reset(rb, 2);
      steps(rb, len);
    end
    steps(3'b111, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
